// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus: the bus-master FSM encoding, the
// peripheral address window, and the timer's register map.
package periph_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } bus_state_t;

  // Upper half-word that selects the peripheral region 0xFFFF_xxxx.
  localparam logic [15:0] PERIPH_BASE_HI = 16'hFFFF;

  // Device index of the timer (chip select 0).
  localparam int DEV_TIMER = 0;

  // Timer register offsets on the Addr bus.
  localparam logic [11:0] TIMER_COMPARE = 12'h000;
  localparam logic [11:0] TIMER_COUNTER = 12'h100;
  localparam logic [11:0] TIMER_STATUS  = 12'h200;

  // True when the byte address lands on one of the num_dev peripheral slots.
  function automatic logic is_mapped(input logic [31:0] addr, input int num_dev);
    return (addr[31:16] == PERIPH_BASE_HI) &&
           (addr[15:14] == 2'b00) &&
           (int'(addr[13:12]) < num_dev);
  endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: accepts single-word CPU loads/stores over a
// valid/ready handshake, decodes the address to a chip select, runs a fixed
// setup/strobe/hold cycle on the bus and returns read data or an error.
// Every bus and response output is a flop, loaded from next-state values so
// the pins change exactly when the FSM changes state.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int NUM_DEV    = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_DEV-1:0]      CS_N,
  output logic                    RD_N,
  output logic                    WR_N,
  output logic [11:0]             Addr,
  output logic [31:0]             bus_wdata,
  input  logic [NUM_DEV*32-1:0]   bus_rdata
);

  bus_state_t   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         write_q, write_d;
  logic [1:0]   dev_q, dev_d;
  logic         accept;
  logic         req_mapped;
  logic         last_strobe;
  logic         bus_active_d;
  logic [NUM_DEV-1:0] cs_n_d;
  logic [31:0]  rd_sel;

  assign accept      = req_valid && (state_q == ST_IDLE);
  assign req_mapped  = is_mapped(req_addr, NUM_DEV);
  assign last_strobe = (state_q == ST_STROBE) && (cnt_q == 8'd1);

  // Next state and phase counter; the counter reloads on each state entry and
  // the state advances when it reaches 1.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_mapped) begin
            state_d = ST_SETUP;
            cnt_d   = 8'(SETUP_CYC);
          end else begin
            state_d = ST_RESP;
            cnt_d   = 8'd1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_STROBE;
          cnt_d   = 8'(STROBE_CYC);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_HOLD;
          cnt_d   = 8'(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd1) begin
          state_d = ST_RESP;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd1;
      end
    endcase
  end

  // Access attributes as they will be after this edge, so the registered pins
  // already reflect a request accepted in this cycle.
  always_comb begin
    write_d      = accept ? req_write : write_q;
    dev_d        = accept ? req_addr[13:12] : dev_q;
    bus_active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                   (state_d == ST_HOLD);
    cs_n_d       = '1;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (bus_active_d && (dev_d == 2'(i))) cs_n_d[i] = 1'b0;
    end
  end

  // Read-data mux over the per-device DataOut slices.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_q == 2'(i)) rd_sel = bus_rdata[32*i +: 32];
    end
  end

  // State register, captured request, and all registered bus/response pins.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop here
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd1;
      write_q   <= 1'b0;
      dev_q     <= 2'd0;
      req_ready <= 1'b1;
      CS_N      <= '1;
      RD_N      <= 1'b1;
      WR_N      <= 1'b1;
      Addr      <= 12'h000;
      bus_wdata <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      dev_q     <= dev_d;
      req_ready <= (state_d == ST_IDLE);
      CS_N      <= cs_n_d;
      RD_N      <= !((state_d == ST_STROBE) && !write_d);
      WR_N      <= !((state_d == ST_STROBE) && write_d);
      rsp_valid <= (state_d == ST_RESP);
      if (accept) begin
        Addr      <= req_addr[11:0];
        bus_wdata <= req_wdata;
        rsp_err   <= !req_mapped;
        rsp_rdata <= 32'h0;
      end else if (last_strobe && !write_q) begin
        rsp_rdata <= rd_sel;
      end
    end
  end

endmodule
